// File: rtl/phy_stripe_pkg.sv
// phy_stripe_pkg: shared lane types and helpers for the PHY striper / de-striper pair
package phy_stripe_pkg;
  localparam int MAX_LANES = 8;
  localparam int MAX_SEL_W = $clog2(MAX_LANES);
  typedef logic [MAX_SEL_W-1:0] lane_idx_t;
  // A lane carries live data in a partial group only when it was filled before the flush point.
  function automatic logic lane_below(input int unsigned lane, input int unsigned fill);
    return lane < fill;
  endfunction
endpackage

// File: rtl/stripe_out_reg.sv
// stripe_out_reg: registered output slot presenting one lane group at a time
module stripe_out_reg #(
  parameter int DATA_W = 8,
  parameter int NUM_LANES = 4
) (
  input  logic                          clk_2f,
  input  logic                          reset,
  input  logic                          load,
  input  logic                          consume,
  input  logic                          partial,
  input  logic [NUM_LANES-1:0]          mask,
  input  logic [NUM_LANES*DATA_W-1:0]   group,
  output logic [NUM_LANES*DATA_W-1:0]   lane_data,
  output logic [NUM_LANES-1:0]          lane_valid,
  output logic                          flush_pulse
);
  // Reload wins over consume so back-to-back groups leave no gap; an unconsumed group is held.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      lane_data   <= '0;
      lane_valid  <= '0;
      flush_pulse <= 1'b0;
    end else begin
      flush_pulse <= load & partial;
      if (load) begin
        lane_data  <= group;
        lane_valid <= mask;
      end else if (consume) begin
        lane_data  <= '0;
        lane_valid <= '0;
      end
    end
  end
endmodule

// File: rtl/byte_striping_nlane.sv
// byte_striping_nlane: round-robin byte striper over NUM_LANES lanes with backpressure and idle flush
module byte_striping_nlane
  import phy_stripe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_LANES = 4,
  parameter int FLUSH_EN = 1
) (
  input  logic                          clk_2f,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          in_ready,
  input  logic                          lanes_ready,
  output logic [NUM_LANES*DATA_W-1:0]   lane_data,
  output logic [NUM_LANES-1:0]          lane_valid,
  output logic                          flush_pulse
);
  localparam int SEL_W = $clog2(NUM_LANES);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_LANES - 1);
  logic [SEL_W-1:0] sel;
  logic [NUM_LANES-1:0][DATA_W-1:0] staging;
  logic [NUM_LANES*DATA_W-1:0] group;
  logic [NUM_LANES-1:0] mask;
  logic out_full, accept, complete, flush;
  assign out_full = |lane_valid;
  assign in_ready = reset & ((sel != LAST) | ~out_full | lanes_ready);
  assign accept   = valid_in & in_ready;
  assign complete = accept & (sel == LAST);
  assign flush    = (FLUSH_EN != 0) && reset && !valid_in && (sel != '0) && (!out_full || lanes_ready);
  // The completing byte bypasses staging; a flush zeroes lanes that were never filled.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign mask[i] = complete | lane_below(i, 32'(sel));
    assign group[i*DATA_W +: DATA_W] = (complete && i == NUM_LANES - 1) ? data_in :
                                       mask[i] ? staging[i] : '0;
  end
  // Lane pointer and staging buffer; staging is never cleared since mask hides stale bytes.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      sel     <= '0;
      staging <= '0;
    end else if (flush) begin
      sel <= '0;
    end else if (accept) begin
      staging[sel] <= data_in;
      sel          <= complete ? '0 : sel + 1'b1;
    end
  end
  stripe_out_reg #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES)) u_out (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .load        (complete | flush),
    .consume     (lanes_ready),
    .partial     (flush),
    .mask        (mask),
    .group       (group),
    .lane_data   (lane_data),
    .lane_valid  (lane_valid),
    .flush_pulse (flush_pulse)
  );
endmodule

// File: tb/tb_byte_striping_nlane.sv
// tb_byte_striping_nlane: flush and no-flush instances checked against a queue-level model
module tb_byte_striping_nlane;
  logic clk_2f, reset, valid_in, lanes_ready;
  logic [7:0] data_in;
  logic [31:0] ld [2];
  logic [3:0] lv [2];
  logic fp [2], ir [2];
  int checks = 0, failures = 0;
  int m_cnt [2];
  logic [7:0] m_buf [2][4];
  logic [31:0] m_data [2];
  logic [3:0] m_valid [2];
  logic m_fp [2];

  byte_striping_nlane #(.DATA_W(8), .NUM_LANES(4), .FLUSH_EN(0)) u0 (
    .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .data_in(data_in), .in_ready(ir[0]),
    .lanes_ready(lanes_ready), .lane_data(ld[0]), .lane_valid(lv[0]), .flush_pulse(fp[0]));
  byte_striping_nlane #(.DATA_W(8), .NUM_LANES(4), .FLUSH_EN(1)) u1 (
    .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .data_in(data_in), .in_ready(ir[1]),
    .lanes_ready(lanes_ready), .lane_data(ld[1]), .lane_valid(lv[1]), .flush_pulse(fp[1]));

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_rdy(input int k);
    return reset && (m_cnt[k] != 3 || m_valid[k] == 0 || lanes_ready);
  endfunction

  task automatic emit(input int k, input logic [3:0] mk);
    m_data[k] = '0;
    for (int i = 0; i < m_cnt[k]; i++) m_data[k][i*8 +: 8] = m_buf[k][i];
    m_valid[k] = mk;
    m_cnt[k] = 0;
  endtask

  task automatic clear_slot(input int k);
    m_data[k] = '0;
    m_valid[k] = '0;
  endtask

  // Model: k=0 never flushes, k=1 flushes a partial group on idle.
  always @(posedge clk_2f) begin
    for (int k = 0; k < 2; k++) begin
      logic a;
      a = valid_in && m_rdy(k);
      if (!reset) begin
        m_cnt[k] = 0;
        clear_slot(k);
        m_fp[k] = 1'b0;
      end else begin
        m_fp[k] = 1'b0;
        if (a) begin
          m_buf[k][m_cnt[k]] = data_in;
          m_cnt[k]++;
          if (m_cnt[k] == 4) emit(k, 4'hF);
          else if (lanes_ready) clear_slot(k);
        end else if (k == 1 && !valid_in && m_cnt[k] != 0 && (m_valid[k] == 0 || lanes_ready)) begin
          emit(k, 4'((1 << m_cnt[k]) - 1));
          m_fp[k] = 1'b1;
        end else if (lanes_ready) begin
          clear_slot(k);
        end
      end
    end
  end

  // Cycle-by-cycle comparison, sampled mid-low-phase.
  always begin
    @(negedge clk_2f);
    #3;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(m_rdy(k)));
      chk($sformatf("lane_data[%0d]", k), ld[k], m_data[k]);
      chk($sformatf("lane_valid[%0d]", k), 32'(lv[k]), 32'(m_valid[k]));
      chk($sformatf("flush_pulse[%0d]", k), 32'(fp[k]), 32'(m_fp[k]));
    end
  end

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic lr);
    @(negedge clk_2f);
    reset = r;
    valid_in = v;
    data_in = d;
    lanes_ready = lr;
  endtask

  initial begin
    reset = 1'b0;
    valid_in = 1'b0;
    data_in = '0;
    lanes_ready = 1'b1;
    repeat (3) drive(0, 0, 8'h00, 1);
    drive(1, 1, 8'hEE, 1);
    drive(1, 1, 8'hEF, 1);
    drive(0, 1, 8'hE0, 1);
    drive(0, 1, 8'hE1, 1);
    #4;
    chk("reset_in_ready", 32'(ir[1]), 32'd0);
    chk("reset_valid", 32'(lv[1]), 32'd0);
    chk("reset_data", ld[1], 32'd0);
    drive(1, 1, 8'h11, 1);
    drive(1, 1, 8'h22, 1);
    drive(1, 1, 8'h33, 1);
    drive(1, 1, 8'h44, 1);
    drive(1, 0, 8'h00, 1);
    #4;
    chk("full_group_data", ld[1], 32'h44332211);
    chk("full_group_valid", 32'(lv[1]), 32'hF);
    drive(1, 1, 8'hA1, 1);
    drive(1, 1, 8'hA2, 1);
    drive(1, 0, 8'h00, 1);
    drive(1, 0, 8'h00, 1);
    #4;
    chk("flush_valid", 32'(lv[1]), 32'h3);
    chk("flush_data", ld[1], 32'h0000A2A1);
    chk("flush_pulse", 32'(fp[1]), 32'd1);
    for (int i = 1; i <= 7; i++) drive(1, 1, 8'(i), 0);
    drive(1, 1, 8'h08, 0);
    #4;
    chk("stall_in_ready", 32'(ir[1]), 32'd0);
    chk("stall_hold", ld[1], 32'h04030201);
    drive(1, 1, 8'h08, 0);
    drive(1, 1, 8'h08, 1);
    #4;
    chk("unstall_in_ready", 32'(ir[1]), 32'd1);
    drive(1, 0, 8'h00, 0);
    #4;
    chk("reload_data", ld[1], 32'h08070605);
    chk("reload_valid", 32'(lv[1]), 32'hF);
    drive(1, 0, 8'h00, 1);
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 8'($urandom), 1);
      #4;
      chk("stream_in_ready", 32'(ir[1]), 32'd1);
    end
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 1);
    drive(1, 1, 8'h5A, 1);
    repeat (10) drive(1, 0, 8'h00, 1);
    #4;
    chk("noflush_idle_valid", 32'(lv[0]), 32'd0);
    drive(1, 1, 8'h01, 1);
    drive(1, 1, 8'h02, 1);
    drive(1, 1, 8'h03, 1);
    drive(1, 0, 8'h00, 1);
    #4;
    chk("noflush_data", ld[0], 32'h0302015A);
    chk("noflush_valid", 32'(lv[0]), 32'hF);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 300; i++)
        drive(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 9) < 3 + 2 * p),
              8'($urandom), logic'($urandom_range(0, 9) < 4 + p));
    end
    drive(1, 0, 8'h00, 1);
    @(negedge clk_2f);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
